vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Owns the 640x480 raster timing and a single-port 3-bit-per-pixel frame buffer.
- Shares that memory between two users:
  - display fetch: hard real-time, highest priority;
  - a host write port, using a req/ack handshake.
- Drives registered RGB/hsync/vsync to the VGA pins and sits between the pixel-source logic and the board connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch; line total 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch; frame total 525
- ADDR_W, 19, frame-buffer address width (covers 307200 pixels)

Ports:
- clk  in  1  system clock, 2x pixel rate
- reset  in  1  asynchronous, active-high reset
- wr_req  in  1  host write request, held until wr_ack
- wr_addr  in  ADDR_W  linear pixel address (y*H_ACTIVE+x), stable while wr_req
- wr_data  in  3  {r,g,b} pixel value, stable while wr_req
- wr_ack  out  1  one-cycle pulse: write performed (or dropped)
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable (valid with mem_en)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  3  write data
- mem_rdata  in  3  read data, valid the cycle after a read strobe
- red_out, green_out, blue_out  out  1 each  pixel colour
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-cycle pulse when counters wrap to (0,0)

Behaviour:
- Reset (async, immediate):
  - hcount=0, vcount=0, phase=0, fetch address=0;
  - mem_en=0, mem_we=0, wr_ack=0, frame_start=0;
  - rgb=0, hsync=1, vsync=1.
  - A write in flight at reset is discarded without ack. A host still holding wr_req is served after reset.
- Phase: phase toggles every clk. Phase 0 is the display slot; phase 1 is the host slot.
- Counters:
  - advance on every phase-1 cycle;
  - hcount wraps 799 to 0; vcount increments on hcount wrap and wraps 524 to 0.
  - frame_start pulses in the cycle the counters become (0,0).
- Active region: hcount<H_ACTIVE and vcount<V_ACTIVE.
- Display fetch:
  - In phase 0 with the counters in the active region, assert mem_en=1, mem_we=0, mem_addr=fetch address.
  - The fetch address increments after each fetch and returns to 0 when vcount wraps to 0.
- Host grant: a pending wr_req is granted in any cycle not used by a display fetch. That is every phase-1 cycle, plus phase-0 cycles in blanking.
  - Grant drives mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, and wr_ack=1 in the same cycle.
  - Back-to-back: wr_req still high in the cycle after wr_ack is treated as a new request. At most one write per cycle.
  - wr_addr >= H_ACTIVE*V_ACTIVE: acked in the first free cycle with mem_en=0 (dropped).
- Output pipeline:
  - mem_rdata is captured into rgb in phase 1 of the same pixel.
  - hsync, vsync and the active flag are delayed through a matching register, so all pin outputs lag the counters by exactly one pixel (2 clk) and stay mutually aligned.
  - In blanking, rgb=0.
  - hsync=0 for delayed hcount in 656..751; vsync=0 for delayed vcount in 490..491.
- Worst-case host latency: 2 clk from wr_req rise to wr_ack.

Decomposition:
- Shared package vga_pkg:
  - timing constants (H_/V_ totals, sync start/end);
  - FB_PIXELS = H_ACTIVE*V_ACTIVE;
  - a pixel typedef for the 3-bit {r,g,b}.
- One sub-module, vga_timing: the phase, hcount/vcount counters, active/sync decode and frame_start.
- vga_fb_arbiter instantiates vga_timing and adds slot arbitration, fetch addressing and the output pipeline.

Test Plan:
- Reset mid-frame, hold 3 clk, release:
  - during reset, outputs read rgb=0, hsync=1, vsync=1, mem_en=0;
  - the first frame_start occurs 800*525*2 = 840000 clk after release.
- Free-run one frame:
  - hsync low for exactly 192 clk per line, starting 1312 clk after line start plus the 2-clk pipeline;
  - vsync low for 2 lines;
  - 307200 read strobes per frame with addresses 0..307199 in order.
- Preload mem with pixel value = addr[2:0], then run: rgb at visible pixel (x=5, y=0) equals 3'b101, and is 0 throughout blanking.
- Host holds wr_req during the active region: wr_ack only on phase-1 cycles, one per 2 clk. No display read is ever displaced (read count per line = 640).
- Host holds wr_req during vertical blanking: wr_ack every clk. A write to addr 1000 with data 3'b110 reads back 3'b110 on the next frame.
- wr_addr = 307200: acked within 2 clk with mem_we never asserted.
- Reset while wr_req high: no wr_ack during reset; ack follows within 2 clk of release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster constants and the pixel type used by the frame-buffer arbiter.
// Module parameters default to these values; derived values are recomputed per instance.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int ADDR_W    = 19;
  localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } pixel_t;

endpackage

// File: rtl/vga_timing.sv
// Raster timing: clk/2 pixel phase, h/v counters, active and sync decode, frame_start.
// Counters advance at the end of each phase-1 cycle, so one pixel spans two clocks.
module vga_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic phase_o,
  output logic active_o,
  output logic hsync_n_o,
  output logic vsync_n_o,
  output logic frame_wrap_o,
  output logic frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          phase_q;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          frame_start_q;
  logic          line_end, frame_end;

  always_comb begin
    line_end  = phase_q && (hcount_q == H_LAST);
    frame_end = line_end && (vcount_q == V_LAST);
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (phase_q) begin
      if (line_end) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q       <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= ~phase_q;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_end;
    end
  end

  assign phase_o       = phase_q;
  assign active_o      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
  assign hsync_n_o     = !((hcount_q >= H_SS) && (hcount_q < H_SE));
  assign vsync_n_o     = !((vcount_q >= V_SS) && (vcount_q < V_SE));
  assign frame_wrap_o  = frame_end;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display fetch owns phase 0 of visible pixels, the host gets every
// other cycle; fetched pixels and syncs are registered to the pins one pixel behind the raster.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int ADDR_W   = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata,
  output logic              red_out,
  output logic              green_out,
  output logic              blue_out,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(H_ACTIVE * V_ACTIVE);

  logic phase, active, hsync_n, vsync_n, frame_wrap;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i        (clk),
    .rst_i        (reset),
    .phase_o      (phase),
    .active_o     (active),
    .hsync_n_o    (hsync_n),
    .vsync_n_o    (vsync_n),
    .frame_wrap_o (frame_wrap),
    .frame_start_o(frame_start)
  );

  logic              fetch_slot, fetch, host_slot, grant, wr_in_range;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  pixel_t            rgb_q, rgb_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;

  // Bus strobes are gated by reset directly so the memory sees nothing while reset is held.
  always_comb begin
    fetch_slot  = !phase && active;
    fetch       = !reset && fetch_slot;
    host_slot   = !reset && !fetch_slot;
    grant       = host_slot && wr_req;
    wr_in_range = wr_addr < FB_LIMIT;
  end

  assign wr_ack    = grant;
  assign mem_en    = fetch || (grant && wr_in_range);
  assign mem_we    = grant && wr_in_range;
  assign mem_addr  = fetch ? fetch_addr_q : wr_addr;
  assign mem_wdata = wr_data;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (frame_wrap) begin
      fetch_addr_d = '0;
    end else if (fetch_slot) begin
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
    end
  end

  // Phase 1 closes a pixel: read data from its phase-0 fetch and its sync levels land together.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (phase) begin
      rgb_d   = active ? pixel_t'(mem_rdata) : '0;
      hsync_d = hsync_n;
      vsync_d = vsync_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr_q <= '0;
      rgb_q        <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  assign red_out   = rgb_q.r;
  assign green_out = rgb_q.g;
  assign blue_out  = rgb_q.b;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: a full-size instance for 640x480 line timing and a reduced
// 16x8-total raster instance (8x4 visible) for frame-level, host-port and reset scenarios.
module tb_vga_fb_arbiter;

  localparam int AW = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // small instance: H 8+2+3+3 = 16, V 4+1+2+1 = 8, 32 visible pixels, 256 clk per frame
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [2:0]    wr_data = '0;
  logic          wr_ack_s, mem_en_s, mem_we_s, red_s, green_s, blue_s, hsync_s, vsync_s, fs_s;
  logic [AW-1:0] mem_addr_s;
  logic [2:0]    mem_wdata_s;
  logic [2:0]    mem_rdata_s = '0;
  logic [2:0]    fb_mem [0:31];

  vga_fb_arbiter #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack_s), .mem_en(mem_en_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata_s), .red_out(red_s), .green_out(green_s),
    .blue_out(blue_s), .hsync(hsync_s), .vsync(vsync_s), .frame_start(fs_s)
  );

  always @(posedge clk) begin
    if (mem_en_s && mem_addr_s < AW'(32)) begin
      if (mem_we_s) fb_mem[mem_addr_s[4:0]] <= mem_wdata_s;
      else          mem_rdata_s <= fb_mem[mem_addr_s[4:0]];
    end
  end

  // full-size instance, host port idle, memory returns zero
  logic          wr_ack_f, mem_en_f, mem_we_f, red_f, green_f, blue_f, hsync_f, vsync_f, fs_f;
  logic [AW-1:0] mem_addr_f;
  logic [2:0]    mem_wdata_f;
  logic [2:0]    zero3 = '0;
  logic [AW-1:0] zero_addr = '0;
  logic          zero1 = 1'b0;

  vga_fb_arbiter dut_full (
    .clk(clk), .reset(rst), .wr_req(zero1), .wr_addr(zero_addr), .wr_data(zero3),
    .wr_ack(wr_ack_f), .mem_en(mem_en_f), .mem_we(mem_we_f), .mem_addr(mem_addr_f),
    .mem_wdata(mem_wdata_f), .mem_rdata(zero3), .red_out(red_f), .green_out(green_f),
    .blue_out(blue_f), .hsync(hsync_f), .vsync(vsync_f), .frame_start(fs_f)
  );

  int edge_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  int hs_f_fall, hs_f_rise, rd_f_cnt, rd_f_bad, f_misc_bad;
  always @(negedge clk) begin
    if (rst) begin
      hs_f_fall <= -1; hs_f_rise <= -1; rd_f_cnt <= 0; rd_f_bad <= 0; f_misc_bad <= 0;
    end else begin
      if (!hsync_f && hs_f_fall < 0) hs_f_fall <= edge_cnt;
      if (hsync_f && hs_f_fall >= 0 && hs_f_rise < 0) hs_f_rise <= edge_cnt;
      if (edge_cnt < 1600 && mem_en_f) begin
        if (mem_we_f || mem_addr_f != AW'(rd_f_cnt)) rd_f_bad <= rd_f_bad + 1;
        rd_f_cnt <= rd_f_cnt + 1;
      end
      if (!vsync_f || fs_f || wr_ack_f) f_misc_bad <= f_misc_bad + 1;
    end
  end

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      seen = fs_s;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame: got no frame_start, expected one within 600 clk");
    end
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (137) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) #1; else @(negedge clk);
      checks++;
      if ({red_s, green_s, blue_s, hsync_s, vsync_s, mem_en_s, wr_ack_s, fs_s} !== 8'b000_11_000) begin
        errors++;
        $display("FAIL reset_small k=%0d: got rgb/hs/vs/en/ack/fs=%b expected 00011000", k,
                 {red_s, green_s, blue_s, hsync_s, vsync_s, mem_en_s, wr_ack_s, fs_s});
      end
      checks++;
      if ({red_f, green_f, blue_f, hsync_f, vsync_f, mem_en_f} !== 6'b000_11_0) begin
        errors++;
        $display("FAIL reset_full k=%0d: got rgb/hs/vs/en=%b expected 000110", k,
                 {red_f, green_f, blue_f, hsync_f, vsync_f, mem_en_f});
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    n = -1;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (fs_s) begin seen = 1'b1; n = edge_cnt; end
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL first_frame_start: got %0d clk after release, expected 256", n);
    end
  endtask

  task automatic test_frame();
    int p, x, y, q, qx, qy;
    bit vis, qvis;
    logic [2:0] exp_rgb;
    logic exp_hs, exp_vs, exp_en;
    wait_frame();
    for (int c = 0; c < 256; c++) begin
      if (c > 0) @(negedge clk);
      p = c / 2; x = p % 16; y = p / 16; vis = (x < 8) && (y < 4);
      q = (p + 127) % 128; qx = q % 16; qy = q / 16; qvis = (qx < 8) && (qy < 4);
      exp_rgb = qvis ? 3'(qx) : 3'b000;
      exp_hs  = !(qx >= 10 && qx < 13);
      exp_vs  = !(qy >= 5 && qy < 7);
      exp_en  = (c % 2 == 0) && vis;
      checks++;
      if ({red_s, green_s, blue_s, hsync_s, vsync_s, fs_s} !== {exp_rgb, exp_hs, exp_vs, (c == 0)}) begin
        errors++;
        $display("FAIL frame_pins c=%0d: got rgb/hs/vs/fs=%b expected %b", c,
                 {red_s, green_s, blue_s, hsync_s, vsync_s, fs_s}, {exp_rgb, exp_hs, exp_vs, (c == 0)});
      end
      checks++;
      if (mem_en_s !== exp_en || mem_we_s !== 1'b0 || wr_ack_s !== 1'b0 ||
          (exp_en && mem_addr_s !== AW'(y * 8 + x))) begin
        errors++;
        $display("FAIL frame_fetch c=%0d: got en=%b we=%b ack=%b addr=%0d expected en=%b we=0 ack=0 addr=%0d",
                 c, mem_en_s, mem_we_s, wr_ack_s, mem_addr_s, exp_en, y * 8 + x);
      end
      if (c == 12) begin
        checks++;
        if ({red_s, green_s, blue_s} !== 3'b101) begin
          errors++;
          $display("FAIL pixel_x5_y0: got %b expected 101", {red_s, green_s, blue_s});
        end
      end
    end
  endtask

  task automatic test_full_line();
    while (edge_cnt < 1610) @(negedge clk);
    checks++;
    if (hs_f_fall != 1314 || hs_f_rise != 1506) begin
      errors++;
      $display("FAIL full_hsync: got fall=%0d rise=%0d expected fall=1314 rise=1506", hs_f_fall, hs_f_rise);
    end
    checks++;
    if (rd_f_cnt != 640 || rd_f_bad != 0) begin
      errors++;
      $display("FAIL full_line_reads: got %0d reads (%0d out of order) expected 640 (0)", rd_f_cnt, rd_f_bad);
    end
    checks++;
    if (f_misc_bad != 0) begin
      errors++;
      $display("FAIL full_idle_signals: got %0d cycles with vsync low/frame_start/ack expected 0", f_misc_bad);
    end
  endtask

  task automatic test_host_active();
    int p, x, y, rd0, ack0;
    bit host;
    wait_frame();
    rd0 = (mem_en_s && !mem_we_s) ? 1 : 0;
    ack0 = 0;
    wr_addr = AW'(3); wr_data = 3'b011; wr_req = 1'b1;
    for (int c = 1; c < 128; c++) begin
      @(negedge clk);
      p = c / 2; x = p % 16; y = p / 16;
      host = (c % 2 == 1) || !((x < 8) && (y < 4));
      if (c < 32) begin
        if (mem_en_s && !mem_we_s) rd0++;
        if (wr_ack_s) ack0++;
      end
      checks++;
      if (host ? ({wr_ack_s, mem_en_s, mem_we_s} !== 3'b111 || mem_addr_s !== AW'(3) || mem_wdata_s !== 3'b011)
               : ({wr_ack_s, mem_en_s, mem_we_s} !== 3'b010 || mem_addr_s !== AW'(y * 8 + x))) begin
        errors++;
        $display("FAIL host_active c=%0d: got ack/en/we=%b addr=%0d expected %s", c,
                 {wr_ack_s, mem_en_s, mem_we_s}, mem_addr_s, host ? "111 addr 3" : "010 fetch");
      end
    end
    wr_req = 1'b0;
    checks++;
    if (rd0 != 8 || ack0 != 24) begin
      errors++;
      $display("FAIL host_active_line0: got reads=%0d acks=%0d expected reads=8 acks=24", rd0, ack0);
    end
  endtask

  task automatic test_host_blank();
    wait_frame();
    for (int c = 1; c < 256; c++) begin
      @(negedge clk);
      if (c == 127) begin
        wr_addr = AW'(20); wr_data = 3'b110; wr_req = 1'b1;
      end else if (c > 127) begin
        checks++;
        if ({wr_ack_s, mem_en_s, mem_we_s} !== 3'b111 || mem_addr_s !== AW'(20) || mem_wdata_s !== 3'b110) begin
          errors++;
          $display("FAIL host_blank c=%0d: got ack/en/we=%b addr=%0d data=%b expected 111 addr 20 data 110",
                   c, {wr_ack_s, mem_en_s, mem_we_s}, mem_addr_s, mem_wdata_s);
        end
      end
    end
    wr_req = 1'b0;
  endtask

  task automatic test_readback();
    wait_frame();
    for (int c = 1; c <= 74; c++) begin
      @(negedge clk);
      if (c == 72) begin
        checks++;
        if ({red_s, green_s, blue_s} !== 3'b011) begin
          errors++;
          $display("FAIL readback_addr19: got %b expected 011", {red_s, green_s, blue_s});
        end
      end
      if (c == 74) begin
        checks++;
        if ({red_s, green_s, blue_s} !== 3'b110) begin
          errors++;
          $display("FAIL readback_addr20: got %b expected 110", {red_s, green_s, blue_s});
        end
      end
    end
  endtask

  task automatic test_drop();
    wait_frame();
    @(negedge clk);
    wr_addr = AW'(32); wr_data = 3'b111; wr_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({wr_ack_s, mem_en_s, mem_we_s} !== 3'b010 || mem_addr_s !== AW'(1)) begin
      errors++;
      $display("FAIL drop_fetch_cycle: got ack/en/we=%b addr=%0d expected 010 addr 1",
               {wr_ack_s, mem_en_s, mem_we_s}, mem_addr_s);
    end
    @(negedge clk);
    checks++;
    if ({wr_ack_s, mem_en_s, mem_we_s} !== 3'b100) begin
      errors++;
      $display("FAIL drop_ack: got ack/en/we=%b expected 100", {wr_ack_s, mem_en_s, mem_we_s});
    end
    wr_req = 1'b0;
  endtask

  task automatic test_reset_wr_req();
    @(negedge clk);
    rst = 1'b1;
    wr_addr = AW'(7); wr_data = 3'b111; wr_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) #1; else @(negedge clk);
      checks++;
      if (wr_ack_s !== 1'b0 || mem_en_s !== 1'b0) begin
        errors++;
        $display("FAIL reset_req_held k=%0d: got ack=%b en=%b expected 0 0", k, wr_ack_s, mem_en_s);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_ack_s, mem_en_s, mem_we_s} !== 3'b010 || mem_addr_s !== AW'(0)) begin
      errors++;
      $display("FAIL reset_req_first: got ack/en/we=%b addr=%0d expected 010 addr 0",
               {wr_ack_s, mem_en_s, mem_we_s}, mem_addr_s);
    end
    @(negedge clk);
    checks++;
    if ({wr_ack_s, mem_en_s, mem_we_s} !== 3'b111 || mem_addr_s !== AW'(7)) begin
      errors++;
      $display("FAIL reset_req_ack: got ack/en/we=%b addr=%0d expected 111 addr 7",
               {wr_ack_s, mem_en_s, mem_we_s}, mem_addr_s);
    end
    wr_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) fb_mem[i] = 3'(i);
    test_reset();
    test_frame();
    test_full_line();
    test_host_active();
    test_host_blank();
    test_readback();
    test_drop();
    test_reset_wr_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
